// File: rtl/fsm_sequencer.sv
// Parametrised state sequencer: walks states 1..NB_STATES-1 with a programmable dwell,
// one-shot or wrap, synchronous halt; every transition is offered on a drop-not-stall event port.
module fsm_sequencer #(
   parameter int NB_STATES = 7,
   parameter int DWELL_W   = 8,
   localparam int SW       = $clog2(NB_STATES)
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic               start,
   input  logic               halt,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_wrap,
   output logic [SW-1:0]      state,
   output logic               busy,
   output logic               done,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [SW-1:0]      evt_state,
   output logic [SW-1:0]      evt_prev,
   output logic [7:0]         drop_cnt
);

   generate
      if (NB_STATES < 3 || NB_STATES > 256) begin : g_bad_nb_states
         $error("fsm_sequencer: NB_STATES must be in 3..256");
      end
   endgenerate

   localparam logic [SW-1:0] IDLE  = '0;
   localparam logic [SW-1:0] FIRST = SW'(1);
   localparam logic [SW-1:0] LAST  = SW'(NB_STATES - 1);

   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] cnt_nxt;
   logic [DWELL_W-1:0] reload;
   logic [SW-1:0]      state_nxt;
   logic               done_nxt;

   // A dwell of 0 behaves as 1, so both load a counter value of 0.
   assign reload = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      if (state == IDLE) begin
         if (start && !halt) begin
            state_nxt = FIRST;
            cnt_nxt   = reload;
         end
      end else if (halt) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (cnt == '0) begin
         if (state != LAST) begin
            state_nxt = state + FIRST;
            cnt_nxt   = reload;
         end else if (cfg_wrap) begin
            state_nxt = FIRST;
            cnt_nxt   = reload;
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
         end
      end else begin
         cnt_nxt = cnt - DWELL_W'(1);
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         evt_valid <= 1'b0;
         evt_state <= '0;
         evt_prev  <= '0;
         drop_cnt  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= done_nxt;
         if (state_nxt != state) begin
            // A held event is never overwritten; the newcomer is counted as lost instead.
            if (!evt_valid || evt_ready) begin
               evt_valid <= 1'b1;
               evt_state <= state_nxt;
               evt_prev  <= state;
            end else if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fsm_sequencer.sv
// Bench for fsm_sequencer: per-scenario tasks with an event scoreboard fed at stimulus time.
module tb_fsm_sequencer;
   localparam int NB = 7;
   localparam int SW = 3;

   logic          aclk = 1'b0;
   logic          areset;
   logic          start, halt, cfg_wrap, evt_ready;
   logic [7:0]    cfg_dwell;
   logic [SW-1:0] state, evt_state, evt_prev;
   logic          busy, done, evt_valid;
   logic [7:0]    drop_cnt;

   int checks = 0;
   int errors = 0;
   logic [2*SW-1:0] sb[$];

   fsm_sequencer #(.NB_STATES(NB), .DWELL_W(8)) dut (
      .aclk(aclk), .areset(areset), .start(start), .halt(halt),
      .cfg_dwell(cfg_dwell), .cfg_wrap(cfg_wrap), .state(state), .busy(busy),
      .done(done), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_state(evt_state), .evt_prev(evt_prev), .drop_cnt(drop_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [2*SW-1:0] ev(input int prev, input int nxt);
      return {SW'(prev), SW'(nxt)};
   endfunction

   // Scoreboard consumer: each handshake due at the next edge pops one expected event.
   always @(negedge aclk) begin
      if (!areset && evt_valid && evt_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got prev=%0d state=%0d expected none", evt_prev, evt_state);
         end else begin
            logic [2*SW-1:0] e;
            e = sb.pop_front();
            if ({evt_prev, evt_state} !== e) begin
               errors++;
               $display("FAIL sb_event got prev=%0d state=%0d expected prev=%0d state=%0d",
                        evt_prev, evt_state, e[2*SW-1:SW], e[SW-1:0]);
            end
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1; start = 0; halt = 0; cfg_dwell = 8'd2; cfg_wrap = 0; evt_ready = 1;
      repeat (3) tick();
      checks++; if (state !== 0 || busy !== 0 || done !== 0) begin errors++;
         $display("FAIL reset_ctl got state=%0d busy=%0d done=%0d expected 0 0 0", state, busy, done); end
      checks++; if (evt_valid !== 0 || evt_state !== 0 || evt_prev !== 0) begin errors++;
         $display("FAIL reset_evt got v=%0d s=%0d p=%0d expected 0 0 0", evt_valid, evt_state, evt_prev); end
      checks++; if (drop_cnt !== 0) begin errors++;
         $display("FAIL reset_drop got %0d expected 0", drop_cnt); end
      areset = 1'b0;
      tick();
   endtask

   task automatic test_one_shot();
      cfg_dwell = 8'd2; cfg_wrap = 0; evt_ready = 1;
      for (int k = 0; k < NB - 1; k++) sb.push_back(ev(k, k + 1));
      sb.push_back(ev(NB - 1, 0));
      pulse_start();
      for (int j = 0; j < 12; j++) begin
         checks++; if (state !== SW'(j / 2 + 1) || busy !== 1 || done !== 0) begin errors++;
            $display("FAIL oneshot_seq j=%0d got state=%0d busy=%0d done=%0d expected %0d 1 0",
                     j, state, busy, done, j / 2 + 1); end
         tick();
      end
      checks++; if (state !== 0 || done !== 1 || busy !== 0) begin errors++;
         $display("FAIL oneshot_end got state=%0d done=%0d busy=%0d expected 0 1 0", state, done, busy); end
      tick();
      checks++; if (done !== 0 || drop_cnt !== 0) begin errors++;
         $display("FAIL oneshot_after got done=%0d drop=%0d expected 0 0", done, drop_cnt); end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL oneshot_drain got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_wrap_halt();
      cfg_dwell = 8'd0; cfg_wrap = 1; evt_ready = 1;
      sb.push_back(ev(0, 1));
      for (int j = 1; j < 16; j++) sb.push_back(ev((j - 1) % 6 + 1, j % 6 + 1));
      sb.push_back(ev(4, 0));
      pulse_start();
      for (int j = 0; j < 16; j++) begin
         checks++; if (state !== SW'(j % 6 + 1) || done !== 0) begin errors++;
            $display("FAIL wrap_seq j=%0d got state=%0d done=%0d expected %0d 0",
                     j, state, done, j % 6 + 1); end
         if (j < 15) tick();
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      checks++; if (state !== 0 || busy !== 0 || done !== 0) begin errors++;
         $display("FAIL wrap_halt got state=%0d busy=%0d done=%0d expected 0 0 0", state, busy, done); end
      tick();
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL wrap_drain got %0d left expected 0", sb.size()); end
      cfg_wrap = 0;
   endtask

   task automatic test_backpressure();
      cfg_dwell = 8'd1; cfg_wrap = 0; evt_ready = 0;
      sb.push_back(ev(0, 1));
      pulse_start();
      for (int j = 0; j < 6; j++) begin
         checks++; if (evt_valid !== 1 || evt_prev !== 0 || evt_state !== 1 || state !== SW'(j + 1)) begin
            errors++;
            $display("FAIL bp_hold j=%0d got v=%0d p=%0d s=%0d state=%0d expected 1 0 1 %0d",
                     j, evt_valid, evt_prev, evt_state, state, j + 1); end
         tick();
      end
      checks++; if (state !== 0 || done !== 1 || drop_cnt !== 8'd6) begin errors++;
         $display("FAIL bp_end got state=%0d done=%0d drop=%0d expected 0 1 6", state, done, drop_cnt); end
      evt_ready = 1;
      tick();
      checks++; if (evt_valid !== 0 || sb.size() != 0) begin errors++;
         $display("FAIL bp_release got v=%0d left=%0d expected 0 0", evt_valid, sb.size()); end
   endtask

   task automatic test_saturation();
      cfg_dwell = 8'd0; cfg_wrap = 1; evt_ready = 0;
      sb.push_back(ev(0, 1));
      pulse_start();
      repeat (300) tick();
      checks++; if (drop_cnt !== 8'd255) begin errors++;
         $display("FAIL sat_reach got %0d expected 255", drop_cnt); end
      repeat (10) tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      checks++; if (drop_cnt !== 8'd255 || state !== 0 || evt_prev !== 0 || evt_state !== 1) begin errors++;
         $display("FAIL sat_hold got drop=%0d state=%0d p=%0d s=%0d expected 255 0 0 1",
                  drop_cnt, state, evt_prev, evt_state); end
      cfg_wrap = 0; evt_ready = 1;
      tick();
      checks++; if (evt_valid !== 0 || sb.size() != 0) begin errors++;
         $display("FAIL sat_release got v=%0d left=%0d expected 0 0", evt_valid, sb.size()); end
   endtask

   task automatic test_corners();
      int exp_cfg[9] = '{1, 1, 1, 2, 3, 4, 5, 6, 0};
      // start while busy: the run must be an untouched dwell-2 one-shot
      cfg_dwell = 8'd2; cfg_wrap = 0; evt_ready = 1;
      for (int k = 0; k < NB - 1; k++) sb.push_back(ev(k, k + 1));
      sb.push_back(ev(NB - 1, 0));
      pulse_start();
      for (int j = 0; j < 13; j++) begin
         start = (j == 3 || j == 11);
         checks++; if (state !== SW'(j < 12 ? j / 2 + 1 : 0) || done !== (j == 12)) begin errors++;
            $display("FAIL busy_start j=%0d got state=%0d done=%0d expected %0d %0d",
                     j, state, done, j < 12 ? j / 2 + 1 : 0, j == 12); end
         tick();
      end
      start = 0;
      // start together with halt in IDLE
      start = 1; halt = 1;
      tick();
      start = 0; halt = 0;
      checks++; if (state !== 0 || busy !== 0 || evt_valid !== 0) begin errors++;
         $display("FAIL start_halt got state=%0d busy=%0d v=%0d expected 0 0 0", state, busy, evt_valid); end
      // dwell changed mid-state applies from the next entry only
      cfg_dwell = 8'd3;
      for (int k = 0; k < NB - 1; k++) sb.push_back(ev(k, k + 1));
      sb.push_back(ev(NB - 1, 0));
      pulse_start();
      for (int j = 0; j < 9; j++) begin
         if (j == 1) cfg_dwell = 8'd1;
         checks++; if (state !== SW'(exp_cfg[j]) || done !== (j == 8)) begin errors++;
            $display("FAIL cfg_change j=%0d got state=%0d done=%0d expected %0d %0d",
                     j, state, done, exp_cfg[j], j == 8); end
         tick();
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL corner_drain got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_reset_mid_run();
      cfg_dwell = 8'd2; cfg_wrap = 0; evt_ready = 0;
      sb.push_back(ev(0, 1));
      pulse_start();
      repeat (4) tick();
      checks++; if (state !== 3 || evt_valid !== 1) begin errors++;
         $display("FAIL rst_pre got state=%0d v=%0d expected 3 1", state, evt_valid); end
      areset = 1'b1;
      #1;
      checks++; if (state !== 0 || busy !== 0 || done !== 0 || evt_valid !== 0 ||
                    evt_state !== 0 || evt_prev !== 0 || drop_cnt !== 0) begin errors++;
         $display("FAIL rst_async got state=%0d busy=%0d done=%0d v=%0d s=%0d p=%0d drop=%0d expected all 0",
                  state, busy, done, evt_valid, evt_state, evt_prev, drop_cnt); end
      sb.delete();
      tick();
      areset = 1'b0; evt_ready = 1; cfg_dwell = 8'd1;
      tick();
      for (int k = 0; k < NB - 1; k++) sb.push_back(ev(k, k + 1));
      sb.push_back(ev(NB - 1, 0));
      pulse_start();
      for (int j = 0; j < 7; j++) begin
         checks++; if (state !== SW'(j < 6 ? j + 1 : 0) || done !== (j == 6) || drop_cnt !== 0) begin
            errors++;
            $display("FAIL rst_rerun j=%0d got state=%0d done=%0d drop=%0d expected %0d %0d 0",
                     j, state, done, drop_cnt, j < 6 ? j + 1 : 0, j == 6); end
         tick();
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL rst_drain got %0d left expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_wrap_halt();
      test_backpressure();
      test_saturation();
      test_corners();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
